// File: rtl/bus_requester.sv
// bus_requester: device-side agent for the shared arbitrated bus.
// It raises this device's BARQ bit and waits for its BAGD grant and for
// AddressValid. It then counts data beats (DataStrobe qualified by
// TargetReady) until the programmed burst completes, and reports either
// done or a coded failure to local logic.
//
// Optional feature: define BUS_REQ_RETRY_EN to retry grant-timeout and
// arbiter-error failures up to twice per start. This adds the BACKOFF
// state and the retry_cnt output.
//
// Ports:
//   clk, reset (sync, active-low)
//   start, len[3:0]      burst request from local logic (len 0 = 16 beats)
//   busy, done, fail     status; done/fail are one-cycle pulses
//   err_code[2:0]        latched failure cause (100 timeout, 101 grant lost,
//                        0xx arbiter Error)
//   beat, beat_cnt[4:0]  per-beat pulse and beats completed so far
//   BARQ / BAGD          request / grant vectors (bit DEVICE_ID only)
//   AddressValid, TargetReady, DataStrobe, Error[1:0]  arbiter handshake
//   retry_cnt[1:0]       retries used (only with BUS_REQ_RETRY_EN)
module bus_requester #(
  parameter int DeviceMaxNumber = 4,
  parameter int DEVICE_ID       = 0,
  parameter int GRANT_TIMEOUT   = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [3:0]                 len,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic [2:0]                 err_code,
  output logic                       beat,
  output logic [4:0]                 beat_cnt,
  output logic [DeviceMaxNumber-1:0] BARQ,
  input  logic [DeviceMaxNumber-1:0] BAGD,
  input  logic                       AddressValid,
  input  logic                       TargetReady,
  input  logic                       DataStrobe,
  input  logic [1:0]                 Error
`ifdef BUS_REQ_RETRY_EN
  ,
  output logic [1:0]                 retry_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_AV,
    XFER,
    DONE,
    FAIL
`ifdef BUS_REQ_RETRY_EN
    ,
    BACKOFF
`endif
  } state_t;

  localparam logic [7:0] TMO_LIM = 8'(GRANT_TIMEOUT);

  state_t      state_q, state_d;
  logic [4:0]  len_q, len_d;
  logic [4:0]  beat_cnt_q, beat_cnt_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        barq_q, barq_d;
  logic        g;
  logic        beat_ok;
  logic        abort;
  logic [2:0]  abort_code;
  logic        unused_bagd;
`ifdef BUS_REQ_RETRY_EN
  logic [1:0]  retry_q, retry_d;
`endif

  assign g           = BAGD[DEVICE_ID];
  // Only our own grant bit matters; the rest is folded away on purpose.
  assign unused_bagd = ^BAGD;
  assign beat_ok     = g && DataStrobe && TargetReady;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    err_code_d = err_code_q;
    tmo_d      = 8'd0;
    beat       = 1'b0;
    abort      = 1'b0;
    abort_code = 3'b000;
`ifdef BUS_REQ_RETRY_EN
    retry_d    = retry_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = (len == 4'd0) ? 5'd16 : {1'b0, len};
          beat_cnt_d = 5'd0;
          err_code_d = 3'b000;
          state_d    = REQ;
`ifdef BUS_REQ_RETRY_EN
          retry_d    = 2'd0;
`endif
        end
      end
      REQ: begin
        if (g) begin
          state_d = WAIT_AV;
        end else if (tmo_q + 8'd1 == TMO_LIM) begin
          abort      = 1'b1;
          abort_code = 3'b100;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      WAIT_AV: begin
        // Strobes seen here are never counted: the address phase comes first.
        if (!g) begin
          abort      = 1'b1;
          abort_code = 3'b101;
        end else if (Error != 2'b00) begin
          abort      = 1'b1;
          abort_code = {1'b0, Error};
        end else if (AddressValid) begin
          state_d = XFER;
        end
      end
      XFER: begin
        // Error outranks a simultaneous beat.
        if (!g) begin
          abort      = 1'b1;
          abort_code = 3'b101;
        end else if (Error != 2'b00) begin
          abort      = 1'b1;
          abort_code = {1'b0, Error};
        end else if (beat_ok) begin
          beat       = 1'b1;
          beat_cnt_d = (beat_cnt_q == 5'd16) ? 5'd16 : beat_cnt_q + 5'd1;
          if (beat_cnt_q + 5'd1 == len_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      FAIL:    state_d = IDLE;
`ifdef BUS_REQ_RETRY_EN
      BACKOFF: begin
        beat_cnt_d = 5'd0;
        state_d    = REQ;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (abort) begin
      err_code_d = abort_code;
      state_d    = FAIL;
`ifdef BUS_REQ_RETRY_EN
      // Grant loss is final; timeouts and arbiter errors get two retries.
      if (abort_code != 3'b101 && retry_q != 2'd2) begin
        state_d = BACKOFF;
        retry_d = retry_q + 2'd1;
      end
`endif
    end

    // BARQ is registered off the next state so it drops on the same edge
    // that leaves the bus-owning states.
    barq_d = (state_d == REQ) || (state_d == WAIT_AV) || (state_d == XFER);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= 5'd16;
      beat_cnt_q <= 5'd0;
      err_code_q <= 3'b000;
      tmo_q      <= 8'd0;
      barq_q     <= 1'b0;
`ifdef BUS_REQ_RETRY_EN
      retry_q    <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      err_code_q <= err_code_d;
      tmo_q      <= tmo_d;
      barq_q     <= barq_d;
`ifdef BUS_REQ_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  always_comb begin
    BARQ            = '0;
    BARQ[DEVICE_ID] = barq_q;
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign fail     = (state_q == FAIL);
  assign err_code = err_code_q;
  assign beat_cnt = beat_cnt_q;
`ifdef BUS_REQ_RETRY_EN
  assign retry_cnt = retry_q;
`endif

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester (DEVICE_ID=2, 4 devices, timeout 15).
// Per-cycle vector table for the burst, error, grant-loss and reset cases,
// plus hand-written loops for the len=0 stall burst and the grant timeout.
module tb_bus_requester;

  logic       clk = 1'b0;
  logic       rst_n, start, av, tr, ds;
  logic [3:0] len, bagd;
  logic [1:0] err;
  logic       busy, done, fail, beat;
  logic [2:0] err_code;
  logic [4:0] beat_cnt;
  logic [3:0] barq;

  int n_pass  = 0;
  int n_total = 0;

  bus_requester #(.DeviceMaxNumber(4), .DEVICE_ID(2), .GRANT_TIMEOUT(15)) dut (
    .clk(clk), .reset(rst_n), .start(start), .len(len),
    .busy(busy), .done(done), .fail(fail), .err_code(err_code),
    .beat(beat), .beat_cnt(beat_cnt), .BARQ(barq), .BAGD(bagd),
    .AddressValid(av), .TargetReady(tr), .DataStrobe(ds), .Error(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, s;
    logic [3:0] l, b;
    logic       av, tr, ds;
    logic [1:0] e;
    logic       busy, dn, fl, bt;
    logic [4:0] cnt;
    logic [3:0] bq;
    logic [2:0] ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic [3:0] l, logic [3:0] b,
                              logic av_i, logic tr_i, logic ds_i, logic [1:0] e,
                              logic bsy, logic dn, logic fl, logic bt,
                              logic [4:0] cnt, logic [3:0] bq, logic [2:0] ec);
    vec_t v;
    v.r = r; v.s = s; v.l = l; v.b = b; v.av = av_i; v.tr = tr_i; v.ds = ds_i;
    v.e = e; v.busy = bsy; v.dn = dn; v.fl = fl; v.bt = bt; v.cnt = cnt;
    v.bq = bq; v.ec = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(logic r, logic s, logic [3:0] l, logic [3:0] b,
                       logic av_i, logic tr_i, logic ds_i, logic [1:0] e);
    rst_n = r; start = s; len = l; bagd = b; av = av_i; tr = tr_i; ds = ds_i; err = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] B  = 4'b0100;
  localparam logic [3:0] BQ = 4'b0100;

  initial begin
    int nb, nd, fk;
    logic [2:0] fec;
    logic [3:0] fbq;

    // Basic burst len=3; start while busy and start during DONE are ignored.
    vecs.push_back(mk(1,1,3,0,0,0,0,0, 0,0,0,0,0,0 ,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,0,0,0,BQ,0));
    vecs.push_back(mk(1,1,1,0,0,0,0,0, 1,0,0,0,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,0,0,0,0, 1,0,0,0,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,1,1,1,0, 1,0,0,0,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,0,1,1,0, 1,0,0,1,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,0,1,1,0, 1,0,0,1,1,BQ,0));
    vecs.push_back(mk(1,0,0,B,0,1,1,0, 1,0,0,1,2,BQ,0));
    vecs.push_back(mk(1,1,1,0,0,0,0,0, 1,1,0,0,3,0 ,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,3,0 ,0));
    // Arbiter error with strobe after beat 1 of 4; start during FAIL ignored.
    vecs.push_back(mk(1,1,4,0,0,0,0,0, 0,0,0,0,3,0 ,0));
    vecs.push_back(mk(1,0,0,B,0,0,0,0, 1,0,0,0,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,1,0,0,0, 1,0,0,0,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,0,1,1,0, 1,0,0,1,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,0,1,1,2, 1,0,0,0,1,BQ,0));
    vecs.push_back(mk(1,1,2,0,0,0,0,0, 1,0,1,0,1,0 ,3'b010));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,1,0 ,3'b010));
    // Grant lost after beat 2 of 5.
    vecs.push_back(mk(1,1,5,0,0,0,0,0, 0,0,0,0,1,0 ,3'b010));
    vecs.push_back(mk(1,0,0,B,0,0,0,0, 1,0,0,0,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,1,0,0,0, 1,0,0,0,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,0,1,1,0, 1,0,0,1,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,0,1,1,0, 1,0,0,1,1,BQ,0));
    vecs.push_back(mk(1,0,0,0,0,1,1,0, 1,0,0,0,2,BQ,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 1,0,1,0,2,0 ,3'b101));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,2,0 ,3'b101));
    // Reset for one edge after beat 1 of 2.
    vecs.push_back(mk(1,1,2,0,0,0,0,0, 0,0,0,0,2,0 ,3'b101));
    vecs.push_back(mk(1,0,0,B,0,0,0,0, 1,0,0,0,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,1,0,0,0, 1,0,0,0,0,BQ,0));
    vecs.push_back(mk(1,0,0,B,0,1,1,0, 1,0,0,1,0,BQ,0));
    vecs.push_back(mk(0,0,0,B,0,0,0,0, 1,0,0,0,1,BQ,0));
    vecs.push_back(mk(1,0,0,B,0,1,1,0, 0,0,0,0,0,0 ,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0 ,0));

    drive(0,0,0,0,0,0,0,0);
    tick();
    tick();
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset fail", fail, 0);
    chk("reset beat", beat, 0);
    chk("reset beat_cnt", beat_cnt, 0);
    chk("reset BARQ", barq, 0);
    chk("reset err_code", err_code, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].s, vecs[i].l, vecs[i].b,
            vecs[i].av, vecs[i].tr, vecs[i].ds, vecs[i].e);
      @(negedge clk);
      chk($sformatf("row%0d busy", i), busy, vecs[i].busy);
      chk($sformatf("row%0d done", i), done, vecs[i].dn);
      chk($sformatf("row%0d fail", i), fail, vecs[i].fl);
      chk($sformatf("row%0d beat", i), beat, vecs[i].bt);
      chk($sformatf("row%0d beat_cnt", i), beat_cnt, vecs[i].cnt);
      chk($sformatf("row%0d BARQ", i), barq, vecs[i].bq);
      chk($sformatf("row%0d err_code", i), err_code, vecs[i].ec);
      @(posedge clk);
      #1;
    end

    // len=0 burst with TargetReady toggling; a start mid-burst must not
    // change the latched length.
    drive(1,1,0,0,0,0,0,0); tick();
    drive(1,0,0,B,0,0,0,0); tick();
    drive(1,0,0,B,1,0,0,0); tick();
    nb = 0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1, (i == 5), 1, B, 0, (i % 2 == 0), 1, 0);
      @(negedge clk);
      if (beat) nb++;
      if (done) begin
        nd++;
        chk("stall beat_cnt at done", beat_cnt, 16);
      end
      @(posedge clk);
      #1;
    end
    chk("stall beats", nb, 16);
    chk("stall done pulses", nd, 1);

    // Grant timeout: BAGD held 0.
    drive(1,1,1,0,0,0,0,0); tick();
    fk = -1;
    fec = 3'b000;
    fbq = 4'b1111;
    for (int k = 0; k < 40; k++) begin
      drive(1,0,0,0,0,0,0,0);
      @(negedge clk);
      if (fail) begin
        fk = k;
        fec = err_code;
        fbq = barq;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("timeout fail cycle", fk, 15);
    chk("timeout err_code", fec, 3'b100);
    chk("timeout BARQ", fbq, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("timeout then idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
